// File: rtl/exp_addsub_seq_if.sv
// Operand/result handshake bundle for the slice-serial exponent adder.
// master drives operands and result acceptance; slave is the adder.
interface exp_addsub_seq_if #(
  parameter int WIDTH = 9
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             sat;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, sat
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, sat
  );
endinterface

// File: rtl/exp_addsub_seq.sv
// Slice-serial exponent add/sub: SLICE bits per cycle, carry in a flop.
// Define EXP_ADDSUB_SAT_EN for unsigned saturation of the final sum.
module exp_addsub_seq #(
  parameter int WIDTH = 9,
  parameter int SLICE = 3
) (
  input logic              clk,
  input logic              rst,
  exp_addsub_seq_if.slave  bus
);
  localparam int NS  = WIDTH / SLICE;
  localparam int CW  = (NS > 1) ? $clog2(NS) : 1;
  localparam int MSB = WIDTH - 1;

  if (WIDTH % SLICE != 0) begin : g_bad_slice
    $error("WIDTH must be a multiple of SLICE");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             rdy_q;
  logic             vld_q;
`ifdef EXP_ADDSUB_SAT_EN
  logic             sub_q;
  logic             sat_q;
`endif

  logic [SLICE-1:0] sl_a;
  logic [SLICE-1:0] sl_b;
  logic [SLICE:0]   ext;
  logic [WIDTH-1:0] sum_nxt;
  logic             last;
  logic             ovf_nxt;

  // Current slice add and the sum as it will look after this slice.
  always_comb begin
    sl_a    = a_q[cnt*SLICE +: SLICE];
    sl_b    = b_q[cnt*SLICE +: SLICE];
    ext     = {1'b0, sl_a} + {1'b0, sl_b}
            + {{SLICE{1'b0}}, carry};
    sum_nxt = sum_q;
    sum_nxt[cnt*SLICE +: SLICE] = ext[SLICE-1:0];
    last    = (cnt == CW'(NS - 1));
    ovf_nxt = (a_q[MSB] == b_q[MSB])
            && (sum_nxt[MSB] != a_q[MSB]);
  end

  // Control FSM plus datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      rdy_q  <= 1'b1;
      vld_q  <= 1'b0;
`ifdef EXP_ADDSUB_SAT_EN
      sub_q  <= 1'b0;
      sat_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && rdy_q) begin
            a_q   <= bus.a;
            b_q   <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub;
            cnt   <= '0;
            rdy_q <= 1'b0;
            state <= RUN;
`ifdef EXP_ADDSUB_SAT_EN
            sub_q <= bus.sub;
            sat_q <= 1'b0;
`endif
          end
        end
        RUN: begin
          sum_q <= sum_nxt;
          carry <= ext[SLICE];
          cnt   <= cnt + 1'b1;
          if (last) begin
            cout_q <= ext[SLICE];
            ovf_q  <= ovf_nxt;
            vld_q  <= 1'b1;
            state  <= DONE;
`ifdef EXP_ADDSUB_SAT_EN
            if (!sub_q && ext[SLICE]) begin
              sum_q <= '1;
              sat_q <= 1'b1;
            end else if (sub_q && !ext[SLICE]) begin
              sum_q <= '0;
              sat_q <= 1'b1;
            end
`endif
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            vld_q <= 1'b0;
            rdy_q <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = vld_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
`ifdef EXP_ADDSUB_SAT_EN
  assign bus.sat       = sat_q;
`else
  assign bus.sat       = 1'b0;
`endif
endmodule

// File: doc/exp_addsub_seq.md
Name: exp_addsub_seq

Overview:
- Parametrised, slice-serial adder/subtractor for exponent arithmetic in the floating-point ALU.
- Computes A+B or A-B over WIDTH/SLICE cycles, SLICE bits per cycle, with carry held in a flop between slices.
- Valid/ready handshake on both sides.
- Outputs carry/borrow and signed overflow for the exponent-adjust and normalise logic.

Parameters:
- WIDTH, 9, operand and result width in bits.
- SLICE, 3, bits processed per cycle. WIDTH must be an integer multiple of SLICE; elaboration fails otherwise.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operands presented
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A, unsigned / two's complement
- b  input  WIDTH  operand B
- sub  input  1  0 = A+B, 1 = A-B
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  carry out of MSB (for sub: 1 = no borrow)
- ovf  output  1  signed two's-complement overflow
- sat  output  1  result was clamped (see Optional Feature)

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, sat=0, slice counter=0, carry flop=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch a, b' = sub ? ~b : b, carry flop = sub, counter=0, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle add slice [counter*SLICE +: SLICE] of a and b' plus carry flop. Write that slice of sum, update carry flop, increment counter.
  - On the last slice (counter = WIDTH/SLICE-1):
    - cout = final carry.
    - ovf = (a[MSB]==b'[MSB]) && (sum[MSB]!=a[MSB]).
    - Go to DONE.
- DONE:
  - out_valid=1; sum/cout/ovf/sat stable.
  - On out_ready: out_valid=0, go to IDLE. in_ready rises the next cycle; no same-cycle turnaround.
  - out_valid held while out_ready=0, indefinitely.
- Latency: accept at edge N → out_valid=1 after edge N+WIDTH/SLICE. Throughput: one operation per WIDTH/SLICE+2 cycles with out_ready=1.
- sum may be observed changing during RUN. It is valid only when out_valid=1.
- Inputs a, b, sub are sampled only at accept; changes during RUN/DONE are ignored.
- in_valid during RUN/DONE is not accepted; the producer holds it.
- rst mid-RUN or mid-DONE: abandon the operation, return to reset values next edge, no out_valid pulse.
- SLICE=WIDTH is legal: single-cycle RUN, latency 1.
- Wrap-around: result is modulo 2^WIDTH; cout/ovf report the overflow.

Optional Feature:
- Macro EXP_ADDSUB_SAT_EN.
- Defined (unsigned saturation, applied at the DONE transition):
  - Add with cout=1 → sum=all ones, sat=1.
  - Sub with cout=0 (borrow) → sum=0, sat=1.
  - cout and ovf still report raw values.
- Undefined: sum is always the modulo result; sat tied to 0.

Test Plan (WIDTH=9, SLICE=3):
- Carry across a slice boundary: a=0x0FF, b=0x001, sub=0 → after 3 cycles out_valid=1, sum=0x100, cout=0, ovf=1, sat=0.
- Add wrap:
  - a=0x1FF, b=0x001, add, macro off → sum=0x000, cout=1, ovf=0.
  - Macro on → sum=0x1FF, sat=1.
- Subtract with borrow:
  - a=0x005, b=0x007, sub=1, macro off → sum=0x1FE, cout=0, ovf=0.
  - Macro on → sum=0x000, sat=1.
- Subtract, no borrow: a=0x07F (127), b=0x003, sub=1 → sum=0x07C, cout=1, ovf=0.
- Backpressure: a=0x010, b=0x020, out_ready held 0 for 5 cycles.
  - out_valid stays 1, sum=0x030 stable, in_ready=0 throughout.
  - A second in_valid is not accepted until the cycle after the out_ready handshake.
- Reset mid-operation: assert rst on the 2nd RUN cycle → next edge out_valid=0, in_ready=1, sum=0. The following operation a=0x002, b=0x003 gives sum=0x005.
